// File: rtl/get_cert_request_gen_pkg.sv
// Shared types and constants for the GET_CERTIFICATE request sequencer:
// message type, error codes, FSM states and the request header layout.
package get_cert_request_gen_pkg;

    localparam logic [7:0] GET_CERT_TYPE = 8'h81;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_EMPTY = 2'd1,
        ERR_RSP   = 2'd2,
        ERR_OVF   = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT_RSP,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_e;

    // Header byte order, MSB first: version, message type, slot, reserved.
    function automatic logic [31:0] make_header(input logic [7:0] ver, input logic [7:0] slot);
        return {ver, GET_CERT_TYPE, slot, 8'h00};
    endfunction

endpackage

// File: rtl/get_cert_request_gen_len_table.sv
// Per-slot certificate length table plus per-slot certificate count.
// One write port per table, one shared combinational read port.
module get_cert_request_gen_len_table
    import get_cert_request_gen_pkg::*;
#(
    parameter  int NUM_SLOTS = 4,
    parameter  int MAX_CERTS = 8,
    parameter  int LEN_W     = 16,
    localparam int SLOT_W    = $clog2(NUM_SLOTS),
    localparam int IDX_W     = $clog2(MAX_CERTS),
    localparam int CNT_W     = $clog2(MAX_CERTS + 1)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              len_we,
    input  logic              cnt_we,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [LEN_W-1:0]  wr_len,
    input  logic [CNT_W-1:0]  wr_cnt,
    input  logic [SLOT_W-1:0] rd_slot,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [LEN_W-1:0]  rd_len,
    output logic [CNT_W-1:0]  rd_cnt
);

    logic [LEN_W-1:0] len_mem [NUM_SLOTS][MAX_CERTS];
    logic [CNT_W-1:0] cnt_mem [NUM_SLOTS];

    // NOTE: the table is reset on purpose: an unconfigured slot must read as empty (count 0).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                cnt_mem[s] <= '0;
                for (int c = 0; c < MAX_CERTS; c++) begin
                    len_mem[s][c] <= '0;
                end
            end
        end else begin
            if (len_we) len_mem[wr_slot][wr_idx] <= wr_len;
            if (cnt_we) cnt_mem[wr_slot] <= wr_cnt;
        end
    end

    assign rd_len = len_mem[rd_slot][rd_idx];
    assign rd_cnt = cnt_mem[rd_slot];

endmodule

// File: rtl/get_cert_request_gen.sv
// GET_CERTIFICATE request sequencer: walks every certificate of a slot in MAX_CHUNK pieces.
// Optional macro GETCERT_RETRY_EN re-issues a rejected request up to MAX_RETRY times.
module get_cert_request_gen
    import get_cert_request_gen_pkg::*;
#(
    parameter  int         NUM_SLOTS = 4,
    parameter  int         MAX_CERTS = 8,
    parameter  int         LEN_W     = 16,
    parameter  int         OFFSET_W  = 16,
    parameter  int         MAX_CHUNK = 512,
    parameter  logic [7:0] PROTO_VER = 8'h01,
`ifdef GETCERT_RETRY_EN
    parameter  int         MAX_RETRY = 2,
`endif
    localparam int         SLOT_W    = $clog2(NUM_SLOTS),
    localparam int         IDX_W     = $clog2(MAX_CERTS),
    localparam int         CNT_W     = $clog2(MAX_CERTS + 1)
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_len_we,
    input  logic                cfg_cnt_we,
    input  logic [SLOT_W-1:0]   cfg_slot,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic [CNT_W-1:0]    cfg_cnt,
    input  logic                start,
    input  logic [SLOT_W-1:0]   start_slot,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [31:0]         req_header,
    output logic [OFFSET_W-1:0] req_offset,
    output logic [LEN_W-1:0]    req_length,
    input  logic                rsp_valid,
    input  logic                rsp_ok,
    output logic [CNT_W-1:0]    expected_certificates,
    output logic [CNT_W-1:0]    cert_index,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code
);

    localparam logic [LEN_W-1:0] CHUNK = LEN_W'(MAX_CHUNK);

    state_e              state;
    logic [SLOT_W-1:0]   slot_r;
    logic [OFFSET_W-1:0] offset_r;
    logic [LEN_W-1:0]    remaining_r;

    logic                idle, idx_ok, len_we, cnt_we, launch, ovf;
    logic [IDX_W-1:0]    rd_idx;
    logic [LEN_W-1:0]    rd_len;
    logic [CNT_W-1:0]    rd_cnt;
    logic [OFFSET_W-1:0] cand_off;
    logic [LEN_W-1:0]    cand_rem, chunk;
    logic [OFFSET_W:0]   end_sum;

    if (MAX_CERTS == (1 << IDX_W)) begin : g_idx_full
        assign idx_ok = 1'b1;
    end else begin : g_idx_part
        assign idx_ok = (cfg_idx < IDX_W'(MAX_CERTS));
    end

    assign idle   = (state == S_IDLE);
    assign len_we = cfg_len_we && idle && idx_ok;
    assign cnt_we = cfg_cnt_we && idle && (cfg_cnt <= CNT_W'(MAX_CERTS));
    assign rd_idx = (state == S_NEXT) ? IDX_W'(cert_index + CNT_W'(1)) : '0;

    get_cert_request_gen_len_table #(
        .NUM_SLOTS (NUM_SLOTS),
        .MAX_CERTS (MAX_CERTS),
        .LEN_W     (LEN_W)
    ) u_len_table (
        .clk     (clk),
        .reset   (reset),
        .len_we  (len_we),
        .cnt_we  (cnt_we),
        .wr_slot (cfg_slot),
        .wr_idx  (cfg_idx),
        .wr_len  (cfg_len),
        .wr_cnt  (cfg_cnt),
        .rd_slot (slot_r),
        .rd_idx  (rd_idx),
        .rd_len  (rd_len),
        .rd_cnt  (rd_cnt)
    );

    // LOAD starts the first chunk straight from the table so req_valid rises 2 cycles after start.
    // NOTE: every always_comb variable gets a default first, so no path can infer a latch.
    always_comb begin
        cand_off = offset_r;
        cand_rem = remaining_r;
        if (state == S_LOAD) begin
            cand_off = '0;
            cand_rem = rd_len;
        end
        chunk   = (cand_rem > CHUNK) ? CHUNK : cand_rem;
        end_sum = {1'b0, cand_off} + (OFFSET_W + 1)'(chunk);
    end

    assign ovf    = end_sum[OFFSET_W];
    assign launch = ((state == S_LOAD) && (rd_cnt != '0) && (rd_len != '0)) ||
                    ((state == S_NEXT) && (remaining_r != '0));

`ifdef GETCERT_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RETRY_W-1:0] retry_cnt;
`endif

    // NOTE: clocked state uses non-blocking assignments only; later assignments in the block win.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= S_IDLE;
            slot_r                <= '0;
            offset_r              <= '0;
            remaining_r           <= '0;
            req_valid             <= 1'b0;
            req_header            <= '0;
            req_offset            <= '0;
            req_length            <= '0;
            expected_certificates <= '0;
            cert_index            <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            error                 <= 1'b0;
            err_code              <= ERR_NONE;
`ifdef GETCERT_RETRY_EN
            retry_cnt             <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    slot_r <= start_slot;
                    busy   <= 1'b1;
                    state  <= S_LOAD;
                end
                S_LOAD: begin
                    expected_certificates <= rd_cnt;
                    cert_index            <= '0;
                    offset_r              <= '0;
                    remaining_r           <= rd_len;
                    err_code              <= ERR_NONE;
                    if (rd_cnt == '0) begin
                        error    <= 1'b1;
                        err_code <= ERR_EMPTY;
                        state    <= S_ERR;
                    end else if (rd_len == '0) begin
                        state <= S_NEXT;
                    end
                end
                S_ISSUE: if (req_ready) begin
                    req_valid <= 1'b0;
                    state     <= S_WAIT_RSP;
                end
                S_WAIT_RSP: if (rsp_valid) begin
                    if (rsp_ok) begin
                        state <= S_NEXT;
`ifdef GETCERT_RETRY_EN
                    end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        req_valid <= 1'b1;
                        state     <= S_ISSUE;
`endif
                    end else begin
                        error    <= 1'b1;
                        err_code <= ERR_RSP;
                        state    <= S_ERR;
                    end
                end
                S_NEXT: if (remaining_r == '0) begin
                    if (cert_index + CNT_W'(1) >= expected_certificates) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cert_index  <= cert_index + CNT_W'(1);
                        remaining_r <= rd_len;
                    end
                end
                S_DONE, S_ERR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // New chunk: offset/remaining advance once here, so a retry reusing req_* never double-counts.
            if (launch) begin
                if (ovf) begin
                    error    <= 1'b1;
                    err_code <= ERR_OVF;
                    state    <= S_ERR;
                end else begin
                    req_valid   <= 1'b1;
                    req_header  <= make_header(PROTO_VER, 8'(slot_r));
                    req_offset  <= cand_off;
                    req_length  <= chunk;
                    offset_r    <= end_sum[OFFSET_W-1:0];
                    remaining_r <= cand_rem - chunk;
                    state       <= S_ISSUE;
`ifdef GETCERT_RETRY_EN
                    retry_cnt   <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_get_cert_request_gen.sv
// Directed bench for get_cert_request_gen: default instance (MAX_CHUNK=512) and a
// second instance with MAX_CHUNK=65535 for the offset-overflow case.
module tb_get_cert_request_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_len_we, cfg_cnt_we;
    logic [1:0]  cfg_slot;
    logic [2:0]  cfg_idx;
    logic [15:0] cfg_len;
    logic [3:0]  cfg_cnt;
    logic        start;
    logic [1:0]  start_slot;
    logic        req_ready, rsp_valid, rsp_ok;

    logic        a_req_valid, a_busy, a_done, a_error;
    logic [31:0] a_req_header;
    logic [15:0] a_req_offset, a_req_length;
    logic [3:0]  a_exp, a_ci;
    logic [1:0]  a_err_code;

    logic        b_req_valid, b_busy, b_done, b_error;
    logic [31:0] b_req_header;
    logic [15:0] b_req_offset, b_req_length;
    logic [3:0]  b_exp, b_ci;
    logic [1:0]  b_err_code;

    logic        sel_big = 1'b0;
    logic        m_req_valid, m_busy, m_done, m_error;
    logic [31:0] m_req_header;
    logic [15:0] m_req_offset, m_req_length;
    logic [3:0]  m_exp, m_ci;
    logic [1:0]  m_err_code;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    get_cert_request_gen dut (
        .clk(clk), .reset(reset),
        .cfg_len_we(cfg_len_we), .cfg_cnt_we(cfg_cnt_we), .cfg_slot(cfg_slot),
        .cfg_idx(cfg_idx), .cfg_len(cfg_len), .cfg_cnt(cfg_cnt),
        .start(start), .start_slot(start_slot),
        .req_valid(a_req_valid), .req_ready(req_ready), .req_header(a_req_header),
        .req_offset(a_req_offset), .req_length(a_req_length),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok),
        .expected_certificates(a_exp), .cert_index(a_ci),
        .busy(a_busy), .done(a_done), .error(a_error), .err_code(a_err_code)
    );

    get_cert_request_gen #(.MAX_CHUNK(65535)) dut_big (
        .clk(clk), .reset(reset),
        .cfg_len_we(cfg_len_we), .cfg_cnt_we(cfg_cnt_we), .cfg_slot(cfg_slot),
        .cfg_idx(cfg_idx), .cfg_len(cfg_len), .cfg_cnt(cfg_cnt),
        .start(start), .start_slot(start_slot),
        .req_valid(b_req_valid), .req_ready(req_ready), .req_header(b_req_header),
        .req_offset(b_req_offset), .req_length(b_req_length),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok),
        .expected_certificates(b_exp), .cert_index(b_ci),
        .busy(b_busy), .done(b_done), .error(b_error), .err_code(b_err_code)
    );

    assign m_req_valid  = sel_big ? b_req_valid  : a_req_valid;
    assign m_req_header = sel_big ? b_req_header : a_req_header;
    assign m_req_offset = sel_big ? b_req_offset : a_req_offset;
    assign m_req_length = sel_big ? b_req_length : a_req_length;
    assign m_exp        = sel_big ? b_exp        : a_exp;
    assign m_ci         = sel_big ? b_ci         : a_ci;
    assign m_busy       = sel_big ? b_busy       : a_busy;
    assign m_done       = sel_big ? b_done       : a_done;
    assign m_error      = sel_big ? b_error      : a_error;
    assign m_err_code   = sel_big ? b_err_code   : a_err_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [1:0] s);
        return {8'h01, 8'h81, 6'd0, s, 8'h00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input logic [1:0] s, input logic [2:0] i, input logic [15:0] l);
        cfg_len_we = 1'b1; cfg_slot = s; cfg_idx = i; cfg_len = l;
        tick();
        cfg_len_we = 1'b0;
    endtask

    task automatic set_cnt(input logic [1:0] s, input logic [3:0] c);
        cfg_cnt_we = 1'b1; cfg_slot = s; cfg_cnt = c;
        tick();
        cfg_cnt_we = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] s);
        start = 1'b1; start_slot = s;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!m_req_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req_seen"}, m_req_valid, 1);
    endtask

    // Wait for a request, check it, accept it in one cycle.
    task automatic issue(input string tag, input logic [1:0] s, input logic [15:0] off,
                         input logic [15:0] len, input logic [3:0] ci);
        wait_req(tag);
        check({tag, "_hdr"}, m_req_header, hdr(s));
        check({tag, "_off"}, m_req_offset, off);
        check({tag, "_len"}, m_req_length, len);
        check({tag, "_ci"},  m_ci, ci);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check({tag, "_valid_drop"}, m_req_valid, 0);
    endtask

    task automatic respond(input logic ok);
        rsp_valid = 1'b1; rsp_ok = ok;
        tick();
        rsp_valid = 1'b0; rsp_ok = 1'b0;
    endtask

    task automatic wait_end(input string tag, input logic exp_err, input logic [1:0] exp_code);
        int   n = 0;
        logic saw_req = 1'b0;
        while (!(m_done || m_error) && n < 20) begin
            if (m_req_valid) saw_req = 1'b1;
            tick();
            n++;
        end
        check({tag, "_done"},   m_done, !exp_err);
        check({tag, "_error"},  m_error, exp_err);
        if (exp_err) check({tag, "_code"}, m_err_code, exp_code);
        check({tag, "_no_req"}, saw_req | m_req_valid, 0);
        tick();
        check({tag, "_pulse_end"}, m_done | m_error, 0);
        check({tag, "_idle"},      m_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; cfg_len_we = 1'b0; cfg_cnt_we = 1'b0;
        cfg_slot = '0; cfg_idx = '0; cfg_len = '0; cfg_cnt = '0;
        start = 1'b0; start_slot = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_ok = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_req_valid", a_req_valid, 0);
        check("rst_busy",      a_busy, 0);
        check("rst_done",      a_done, 0);
        check("rst_error",     a_error, 0);
        check("rst_err_code",  a_err_code, 0);
        check("rst_header",    a_req_header, 0);
        check("rst_offset",    a_req_offset, 0);
        check("rst_length",    a_req_length, 0);
        check("rst_expected",  a_exp, 0);
        check("rst_cert_idx",  a_ci, 0);

        set_len(0, 0, 16'd1000);
        set_len(0, 1, 16'd300);
        set_cnt(0, 4'd2);
        set_len(2, 0, 16'd100);
        set_len(2, 1, 16'd0);
        set_len(2, 2, 16'd50);
        set_cnt(2, 4'd3);
        set_cnt(3, 4'd9);

        // T1: two certificates split into three chunks
        do_start(0);
        check("t1_busy",    a_busy, 1);
        check("t1_early",   a_req_valid, 0);
        tick();
        check("t1_latency", a_req_valid, 1);
        check("t1_expected", a_exp, 2);
        issue("t1a", 0, 16'd0, 16'd512, 4'd0);
        start = 1'b1; start_slot = 2'd1;
        cfg_cnt_we = 1'b1; cfg_slot = 2'd1; cfg_cnt = 4'd1;
        tick();
        start = 1'b0; cfg_cnt_we = 1'b0;
        check("t1_busy_start_ignored", a_req_valid, 0);
        respond(1'b1);
        issue("t1b", 0, 16'd512, 16'd488, 4'd0);
        respond(1'b1);
        issue("t1c", 0, 16'd1000, 16'd300, 4'd1);
        respond(1'b1);
        wait_end("t1", 1'b0, 2'd0);

        // T2: empty slot (cnt write while busy was dropped) errors on cycle 2
        do_start(1);
        check("t2_cycle1_error", a_error, 0);
        tick();
        check("t2_error",    a_error, 1);
        check("t2_code",     a_err_code, 1);
        check("t2_no_req",   a_req_valid, 0);
        tick();
        check("t2_pulse_end", a_error, 0);
        check("t2_idle",      a_busy, 0);

        // Count > MAX_CERTS was dropped, so slot 3 is still empty
        do_start(3);
        wait_end("t_cnt_drop", 1'b1, 2'd1);

        // Zero-length middle certificate is skipped without a request
        do_start(2);
        issue("t7a", 2, 16'd0, 16'd100, 4'd0);
        respond(1'b1);
        issue("t7b", 2, 16'd100, 16'd50, 4'd2);
        respond(1'b1);
        wait_end("t7", 1'b0, 2'd0);

        // T3: back-pressure holds the request; stray rsp_valid in ISSUE is ignored
        do_start(0);
        wait_req("t3");
        for (int i = 0; i < 5; i++) begin
            rsp_valid = (i == 0);
            tick();
            rsp_valid = 1'b0;
            check("t3_hold_valid", a_req_valid, 1);
            check("t3_hold_hdr",   a_req_header, hdr(0));
            check("t3_hold_off",   a_req_offset, 0);
            check("t3_hold_len",   a_req_length, 512);
        end
        req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_single_xfer", a_req_valid, 0);
        end
        req_ready = 1'b0;
        respond(1'b1);

        // T4: responder error on the second chunk
        issue("t4", 0, 16'd512, 16'd488, 4'd0);
        respond(1'b0);
`ifdef GETCERT_RETRY_EN
        for (int r = 0; r < 2; r++) begin
            issue("t4_retry", 0, 16'd512, 16'd488, 4'd0);
            respond(1'b0);
        end
`endif
        wait_end("t4", 1'b1, 2'd2);

        // T5: reset while waiting for a response aborts silently
        do_start(0);
        issue("t5a", 0, 16'd0, 16'd512, 4'd0);
        reset = 1'b1;
        tick();
        check("t5_busy",  a_busy, 0);
        check("t5_valid", a_req_valid, 0);
        check("t5_done",  a_done, 0);
        check("t5_error", a_error, 0);
        reset = 1'b0;
        set_len(0, 0, 16'd1000);
        set_len(0, 1, 16'd300);
        set_cnt(0, 4'd2);
        do_start(0);
        wait_req("t5b");
        check("t5b_off", a_req_offset, 0);
        check("t5b_len", a_req_length, 512);
        pulse_reset();

        // T6: second request would run past the 16-bit offset space
        set_len(0, 0, 16'd65000);
        set_len(0, 1, 16'd1000);
        set_cnt(0, 4'd2);
        sel_big = 1'b1;
        do_start(0);
        issue("t6", 0, 16'd0, 16'd65000, 4'd0);
        check("t6_expected", m_exp, 2);
        respond(1'b1);
        wait_end("t6", 1'b1, 2'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
